// File: rtl/bellek_hakemi_pkg.sv
// Shared definitions for the bellek_hakemi memory arbiter:
// state encodings, owner encoding and the default burst length.
package bellek_hakemi_pkg;

    localparam int VARSAYILAN_OBEK_UZUNLUK = 4;

    typedef enum logic [1:0] {
        HAKEM_BOSTA = 2'd0,
        HAKEM_L1B   = 2'd1,
        HAKEM_L1V   = 2'd2
    } hakem_durum_e;

    typedef enum logic {
        SAHIP_L1B = 1'b0,
        SAHIP_L1V = 1'b1
    } sahip_e;

endpackage

// File: rtl/bellek_hakemi_if.sv
// Signal bundle between the L1 caches, the arbiter and the memory word port.
// Handshake: a memory beat transfers in every cycle with bellek_istek_o && bellek_hazir_i;
// a requester holds istek until its bitti_o, and a write word is held until l1v_yaz_hazir_o.
interface bellek_hakemi_if #(
    parameter int ADRES_BIT = 32,
    parameter int VERI_BIT  = 32
);
    logic                 l1b_istek_i;
    logic [ADRES_BIT-1:0] l1b_adres_i;
    logic                 l1b_gecerli_o;
    logic [VERI_BIT-1:0]  l1b_deger_o;
    logic                 l1b_bitti_o;

    logic                 l1v_istek_i;
    logic                 l1v_yaz_i;
    logic [ADRES_BIT-1:0] l1v_adres_i;
    logic [VERI_BIT-1:0]  l1v_yaz_deger_i;
    logic                 l1v_yaz_hazir_o;
    logic                 l1v_gecerli_o;
    logic [VERI_BIT-1:0]  l1v_deger_o;
    logic                 l1v_bitti_o;

    logic                 bellek_istek_o;
    logic                 bellek_yaz_o;
    logic [ADRES_BIT-1:0] bellek_adres_o;
    logic [VERI_BIT-1:0]  bellek_yaz_deger_o;
    logic                 bellek_hazir_i;
    logic [VERI_BIT-1:0]  bellek_deger_i;

    modport slave (
        input  l1b_istek_i, l1b_adres_i,
        output l1b_gecerli_o, l1b_deger_o, l1b_bitti_o,
        input  l1v_istek_i, l1v_yaz_i, l1v_adres_i, l1v_yaz_deger_i,
        output l1v_yaz_hazir_o, l1v_gecerli_o, l1v_deger_o, l1v_bitti_o,
        output bellek_istek_o, bellek_yaz_o, bellek_adres_o, bellek_yaz_deger_o,
        input  bellek_hazir_i, bellek_deger_i
    );

    modport master (
        output l1b_istek_i, l1b_adres_i,
        input  l1b_gecerli_o, l1b_deger_o, l1b_bitti_o,
        output l1v_istek_i, l1v_yaz_i, l1v_adres_i, l1v_yaz_deger_i,
        input  l1v_yaz_hazir_o, l1v_gecerli_o, l1v_deger_o, l1v_bitti_o,
        input  bellek_istek_o, bellek_yaz_o, bellek_adres_o, bellek_yaz_deger_o,
        output bellek_hazir_i, bellek_deger_i
    );

endinterface

// File: rtl/bellek_hakemi_obek_sayaci.sv
// Burst beat counter and address generator: latches the line base at grant
// and produces base + 4*beat, flagging the final beat of the burst.
module bellek_hakemi_obek_sayaci #(
    parameter int ADRES_BIT    = 32,
    parameter int OBEK_UZUNLUK = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 baslat_i,
    input  logic                 ilerle_i,
    input  logic [ADRES_BIT-1:0] base_i,
    output logic [ADRES_BIT-1:0] adres_o,
    output logic                 son_o
);
    localparam int SAYAC_BIT = $clog2(OBEK_UZUNLUK);
    localparam logic [SAYAC_BIT-1:0] SON_SAYAC = SAYAC_BIT'(OBEK_UZUNLUK - 1);

    logic [SAYAC_BIT-1:0] sayac_q, sayac_d;
    logic [ADRES_BIT-1:0] base_q, base_d;

    always_comb begin
        sayac_d = sayac_q;
        base_d  = base_q;
        if (baslat_i) begin
            sayac_d = '0;
            base_d  = base_i;
        end else if (ilerle_i) begin
            sayac_d = son_o ? '0 : sayac_q + SAYAC_BIT'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sayac_q <= '0;
            base_q  <= '0;
        end else begin
            sayac_q <= sayac_d;
            base_q  <= base_d;
        end
    end

    // Base is line aligned, so the sum never carries out of the line; the
    // top bits wrap naturally modulo 2^ADRES_BIT.
    assign adres_o = base_q + ADRES_BIT'({sayac_q, 2'b00});
    assign son_o   = (sayac_q == SON_SAYAC);

endmodule

// File: rtl/bellek_hakemi.sv
// Memory word-port arbiter between the L1 instruction and data caches; each grant is a fixed burst.
// Define BELLEK_HAKEMI_ADIL_EN for round-robin tie breaking instead of fixed l1v priority.
module bellek_hakemi
    import bellek_hakemi_pkg::*;
#(
    parameter int ADRES_BIT    = 32,
    parameter int VERI_BIT     = 32,
    parameter int OBEK_UZUNLUK = VARSAYILAN_OBEK_UZUNLUK
) (
    input  logic           clk_i,
    input  logic           rst_i,
    bellek_hakemi_if.slave hakem,
    output hakem_durum_e   durum_o
);
    localparam logic [ADRES_BIT-1:0] HIZA_MASKE = ADRES_BIT'(OBEK_UZUNLUK * 4 - 1);

    hakem_durum_e         durum_q, durum_d;
    logic                 yaz_q, yaz_d;
    logic                 baslat;
    logic                 ilerle;
    logic                 son;
    logic [ADRES_BIT-1:0] taban;
    logic [ADRES_BIT-1:0] adres;
    logic                 l1v_kazanir;

`ifdef BELLEK_HAKEMI_ADIL_EN
    sahip_e son_sahip_q, son_sahip_d;

    // On a tie the side that was not granted last wins.
    assign l1v_kazanir = hakem.l1v_istek_i &&
                         (!hakem.l1b_istek_i || (son_sahip_q == SAHIP_L1B));

    always_comb begin
        son_sahip_d = son_sahip_q;
        if (baslat) begin
            son_sahip_d = l1v_kazanir ? SAHIP_L1V : SAHIP_L1B;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            son_sahip_q <= SAHIP_L1B;
        end else begin
            son_sahip_q <= son_sahip_d;
        end
    end
`else
    assign l1v_kazanir = hakem.l1v_istek_i;
`endif

    always_comb begin
        durum_d = durum_q;
        yaz_d   = yaz_q;
        baslat  = 1'b0;
        ilerle  = 1'b0;
        taban   = hakem.l1b_adres_i & ~HIZA_MASKE;

        hakem.l1b_gecerli_o      = 1'b0;
        hakem.l1b_deger_o        = '0;
        hakem.l1b_bitti_o        = 1'b0;
        hakem.l1v_yaz_hazir_o    = 1'b0;
        hakem.l1v_gecerli_o      = 1'b0;
        hakem.l1v_deger_o        = '0;
        hakem.l1v_bitti_o        = 1'b0;
        hakem.bellek_istek_o     = 1'b0;
        hakem.bellek_yaz_o       = 1'b0;
        hakem.bellek_adres_o     = '0;
        hakem.bellek_yaz_deger_o = '0;

        // Outputs stay at their zero defaults while reset is held.
        if (!rst_i) begin
            case (durum_q)
                HAKEM_BOSTA: begin
                    if (l1v_kazanir) begin
                        durum_d = HAKEM_L1V;
                        yaz_d   = hakem.l1v_yaz_i;
                        taban   = hakem.l1v_adres_i & ~HIZA_MASKE;
                        baslat  = 1'b1;
                    end else if (hakem.l1b_istek_i) begin
                        durum_d = HAKEM_L1B;
                        yaz_d   = 1'b0;
                        baslat  = 1'b1;
                    end
                end

                HAKEM_L1B, HAKEM_L1V: begin
                    hakem.bellek_istek_o     = 1'b1;
                    hakem.bellek_yaz_o       = yaz_q;
                    hakem.bellek_adres_o     = adres;
                    hakem.bellek_yaz_deger_o = yaz_q ? hakem.l1v_yaz_deger_i : '0;

                    if (hakem.bellek_hazir_i) begin
                        ilerle = 1'b1;
                        if (yaz_q) begin
                            hakem.l1v_yaz_hazir_o = 1'b1;
                        end else if (durum_q == HAKEM_L1V) begin
                            hakem.l1v_gecerli_o = 1'b1;
                            hakem.l1v_deger_o   = hakem.bellek_deger_i;
                        end else begin
                            hakem.l1b_gecerli_o = 1'b1;
                            hakem.l1b_deger_o   = hakem.bellek_deger_i;
                        end

                        if (son) begin
                            durum_d = HAKEM_BOSTA;
                            if (durum_q == HAKEM_L1V) begin
                                hakem.l1v_bitti_o = 1'b1;
                            end else begin
                                hakem.l1b_bitti_o = 1'b1;
                            end
                        end
                    end
                end

                default: durum_d = HAKEM_BOSTA;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            durum_q <= HAKEM_BOSTA;
            yaz_q   <= 1'b0;
        end else begin
            durum_q <= durum_d;
            yaz_q   <= yaz_d;
        end
    end

    bellek_hakemi_obek_sayaci #(
        .ADRES_BIT    (ADRES_BIT),
        .OBEK_UZUNLUK (OBEK_UZUNLUK)
    ) u_obek_sayaci (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .baslat_i (baslat),
        .ilerle_i (ilerle),
        .base_i   (taban),
        .adres_o  (adres),
        .son_o    (son)
    );

    assign durum_o = rst_i ? HAKEM_BOSTA : durum_q;

endmodule

// File: tb/tb_bellek_hakemi.sv
// Bench for bellek_hakemi: directed vector table, hand-written reset/tie/wrap
// sequences, and randomized bursts checked against a transaction-level model.
module tb_bellek_hakemi;
    import bellek_hakemi_pkg::*;

    localparam int AB  = 32;
    localparam int VB  = 32;
    localparam int OU  = 4;
    localparam int HAT = OU * 4;

    typedef logic [134:0] cikis_t;

    typedef struct {
        logic        b;
        logic [31:0] ba;
        logic        v;
        logic        vy;
        logic [31:0] va;
        logic [31:0] vw;
        logic        hz;
        logic [31:0] rd;
        cikis_t      beklenen;
    } vek_t;

    logic         clk;
    logic         rst;
    hakem_durum_e durum;
    int           vektor;
    int           hata;
    logic         son_v;
    vek_t         tablo[$];
    logic [31:0]  exp_q[$];

    bellek_hakemi_if #(.ADRES_BIT(AB), .VERI_BIT(VB)) bus ();

    bellek_hakemi #(
        .ADRES_BIT    (AB),
        .VERI_BIT     (VB),
        .OBEK_UZUNLUK (OU)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .hakem   (bus),
        .durum_o (durum)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    function automatic cikis_t bk(input logic istek, input logic yaz,
                                  input logic [31:0] adres, input logic [31:0] wdata,
                                  input logic bg, input logic [31:0] bd, input logic bb,
                                  input logic vg, input logic [31:0] vd, input logic vb,
                                  input logic vh);
        return {istek, yaz, adres, wdata, bg, bd, bb, vg, vd, vb, vh};
    endfunction

    function automatic cikis_t gozle();
        return {bus.bellek_istek_o, bus.bellek_yaz_o, bus.bellek_adres_o, bus.bellek_yaz_deger_o,
                bus.l1b_gecerli_o, bus.l1b_deger_o, bus.l1b_bitti_o,
                bus.l1v_gecerli_o, bus.l1v_deger_o, bus.l1v_bitti_o, bus.l1v_yaz_hazir_o};
    endfunction

    task automatic kontrol(input string ad, input cikis_t gercek, input cikis_t beklenen);
        vektor++;
        if (gercek !== beklenen) begin
            hata++;
            $display("FAIL %s: got %h expected %h", ad, gercek, beklenen);
        end
    endtask

    task automatic tik();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver ----------------
    task automatic sur(input logic b, input logic [31:0] ba, input logic v, input logic vy,
                       input logic [31:0] va, input logic [31:0] vw, input logic hz,
                       input logic [31:0] rd);
        bus.l1b_istek_i     = b;
        bus.l1b_adres_i     = ba;
        bus.l1v_istek_i     = v;
        bus.l1v_yaz_i       = vy;
        bus.l1v_adres_i     = va;
        bus.l1v_yaz_deger_i = vw;
        bus.bellek_hazir_i  = hz;
        bus.bellek_deger_i  = rd;
    endtask

    function automatic void ekle(input logic b, input logic [31:0] ba, input logic v,
                                 input logic vy, input logic [31:0] va, input logic [31:0] vw,
                                 input logic hz, input logic [31:0] rd, input cikis_t e);
        tablo.push_back('{b, ba, v, vy, va, vw, hz, rd, e});
    endfunction

    // ---------------- reference model + scoreboard ----------------
    // One request slot in an idle cycle, then the granted burst with random
    // memory wait states. The winner comes from the arbitration rule; beat
    // addresses come from line arithmetic on the requested address.
    task automatic olay(input logic b, input logic [31:0] ba, input logic v, input logic vy,
                        input logic [31:0] va, input bit birak);
        int          sahip;
        logic        yaz;
        logic        v_once;
        logic [31:0] taban;
        logic [31:0] kelime[$];
        int          bekleme;
        int          tamam;
        logic        hz;
        logic [31:0] rd;
        logic        ob;
        logic        ov;
        logic        sonuncu;
        cikis_t      e;

`ifdef BELLEK_HAKEMI_ADIL_EN
        v_once = !son_v;
`else
        v_once = 1'b1;
`endif
        if (v && (!b || v_once)) sahip = 2;
        else if (b) sahip = 1;
        else sahip = 0;

        yaz   = (sahip == 2) && vy;
        taban = (sahip == 2) ? va - (va % 32'(HAT)) : ba - (ba % 32'(HAT));
        exp_q.delete();
        kelime.delete();
        if (sahip != 0) begin
            for (int k = 0; k < OU; k++) begin
                exp_q.push_back(taban + 32'(4 * k));
                kelime.push_back($urandom);
            end
        end

        sur(b, ba, v, vy, va, (kelime.size() > 0) ? kelime[0] : 32'h0,
            1'($urandom_range(0, 1)), $urandom);
        #1 kontrol("bosta", gozle(), '0);
        tik();
        if (sahip != 0) son_v = (sahip == 2);

        bekleme = 0;
        tamam   = 0;
        ob      = b;
        ov      = v;
        while (exp_q.size() > 0) begin
            hz = (bekleme >= 3) ? 1'b1 : ($urandom_range(0, 99) < 55);
            rd = $urandom;
            if (birak && tamam >= 1) begin
                if (sahip == 1) ob = 1'b0;
                else ov = 1'b0;
            end
            sur(ob, ba, ov, vy, va, yaz ? kelime[0] : $urandom, hz, rd);
            sonuncu = hz && (exp_q.size() == 1);
            e = bk(1'b1, yaz, exp_q[0], yaz ? kelime[0] : 32'h0,
                   (sahip == 1) && hz, ((sahip == 1) && hz) ? rd : 32'h0, (sahip == 1) && sonuncu,
                   (sahip == 2) && hz && !yaz, ((sahip == 2) && hz && !yaz) ? rd : 32'h0,
                   (sahip == 2) && sonuncu, yaz && hz);
            #1 kontrol("demet", gozle(), e);
            if (hz) begin
                void'(exp_q.pop_front());
                void'(kelime.pop_front());
                bekleme = 0;
                tamam++;
            end else begin
                bekleme++;
            end
            tik();
        end
    endtask

    // ---------------- test ----------------
    initial begin
        vektor = 0;
        hata   = 0;
        son_v  = 1'b0;

        // Tie between read refills: l1v first, l1b after one idle cycle.
        ekle(1, 32'h1234, 1, 0, 32'h3008, 0, 1, 32'hDEAD0000, '0);
        ekle(1, 32'h1234, 1, 0, 32'h3008, 0, 1, 32'hD1, bk(1, 0, 32'h3000, 0, 0, 0, 0, 1, 32'hD1, 0, 0));
        ekle(1, 32'h1234, 1, 0, 32'h3008, 0, 1, 32'hD2, bk(1, 0, 32'h3004, 0, 0, 0, 0, 1, 32'hD2, 0, 0));
        ekle(1, 32'h1234, 1, 0, 32'h3008, 0, 1, 32'hD3, bk(1, 0, 32'h3008, 0, 0, 0, 0, 1, 32'hD3, 0, 0));
        ekle(1, 32'h1234, 1, 0, 32'h3008, 0, 1, 32'hD4, bk(1, 0, 32'h300C, 0, 0, 0, 0, 1, 32'hD4, 1, 0));
        ekle(1, 32'h1234, 0, 0, 32'h0, 0, 1, 32'hD5, '0);
        ekle(1, 32'h1234, 0, 0, 32'h0, 0, 1, 32'hE1, bk(1, 0, 32'h1230, 0, 1, 32'hE1, 0, 0, 0, 0, 0));
        ekle(1, 32'h1234, 0, 0, 32'h0, 0, 1, 32'hE2, bk(1, 0, 32'h1234, 0, 1, 32'hE2, 0, 0, 0, 0, 0));
        ekle(1, 32'h1234, 0, 0, 32'h0, 0, 1, 32'hE3, bk(1, 0, 32'h1238, 0, 1, 32'hE3, 0, 0, 0, 0, 0));
        ekle(1, 32'h1234, 0, 0, 32'h0, 0, 1, 32'hE4, bk(1, 0, 32'h123C, 0, 1, 32'hE4, 1, 0, 0, 0, 0));
        ekle(0, 32'h0, 0, 0, 32'h0, 0, 1, 32'hE5, '0);
        // Writeback at 0x2000 with memory ready pattern 1,0,0,1,1,1.
        ekle(0, 0, 1, 1, 32'h2000, 32'hA0, 1, 32'hBAD0, '0);
        ekle(0, 0, 1, 1, 32'h2000, 32'hA0, 1, 32'hBAD1, bk(1, 1, 32'h2000, 32'hA0, 0, 0, 0, 0, 0, 0, 1));
        ekle(0, 0, 1, 1, 32'h2000, 32'hA1, 0, 32'hBAD2, bk(1, 1, 32'h2004, 32'hA1, 0, 0, 0, 0, 0, 0, 0));
        ekle(0, 0, 1, 1, 32'h2000, 32'hA1, 0, 32'hBAD3, bk(1, 1, 32'h2004, 32'hA1, 0, 0, 0, 0, 0, 0, 0));
        ekle(0, 0, 1, 1, 32'h2000, 32'hA1, 1, 32'hBAD4, bk(1, 1, 32'h2004, 32'hA1, 0, 0, 0, 0, 0, 0, 1));
        ekle(0, 0, 1, 1, 32'h2000, 32'hA2, 1, 32'hBAD5, bk(1, 1, 32'h2008, 32'hA2, 0, 0, 0, 0, 0, 0, 1));
        ekle(0, 0, 1, 1, 32'h2000, 32'hA3, 1, 32'hBAD6, bk(1, 1, 32'h200C, 32'hA3, 0, 0, 0, 0, 0, 1, 1));
        ekle(0, 0, 0, 0, 32'h2000, 32'hA3, 1, 32'hBAD7, '0);

        rst = 1'b1;
        sur(1, 32'h1234, 1, 1, 32'h2000, 32'hFFFF, 1, 32'hFFFF);
        tik();
        tik();
        kontrol("reset_cikis", gozle(), '0);
        kontrol("reset_durum", cikis_t'(durum), '0);
        rst = 1'b0;

        foreach (tablo[i]) begin
            sur(tablo[i].b, tablo[i].ba, tablo[i].v, tablo[i].vy, tablo[i].va,
                tablo[i].vw, tablo[i].hz, tablo[i].rd);
            #1 kontrol($sformatf("tablo[%0d]", i), gozle(), tablo[i].beklenen);
            tik();
        end

        // The table ends with an l1v writeback grant; a fresh tie follows.
        son_v = 1'b1;
        olay(1, 32'h1234, 1, 0, 32'h3008, 0);

        // Requester drops istek after the first beat; address wrap at the top.
        olay(1, 32'h0000_7777, 0, 0, 32'h0, 1);
        olay(1, 32'hFFFF_FFF4, 0, 0, 32'h0, 0);
        olay(0, 32'h0, 1, 1, 32'hFFFF_FFFC, 0);

        // Reset during beat 2 of an l1v burst, then a new l1b request.
        sur(0, 0, 1, 0, 32'h4000, 0, 0, 0);
        #1 kontrol("rst_bosta", gozle(), '0);
        tik();
        sur(0, 0, 1, 0, 32'h4000, 0, 1, 32'h11);
        #1 kontrol("rst_beat0", gozle(), bk(1, 0, 32'h4000, 0, 0, 0, 0, 1, 32'h11, 0, 0));
        tik();
        sur(0, 0, 1, 0, 32'h4000, 0, 1, 32'h22);
        #1 kontrol("rst_beat1", gozle(), bk(1, 0, 32'h4004, 0, 0, 0, 0, 1, 32'h22, 0, 0));
        tik();
        rst = 1'b1;
        sur(1, 32'h5678, 1, 0, 32'h4000, 0, 1, 32'h33);
        #1 kontrol("rst_sirasinda", gozle(), '0);
        kontrol("rst_durum", cikis_t'(durum), '0);
        tik();
        rst   = 1'b0;
        son_v = 1'b0;
        olay(1, 32'h5678, 0, 0, 32'h0, 0);

        for (int n = 0; n < 150; n++) begin
            olay(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vektor, hata);
        $finish;
    end

endmodule
